matrix_scan_driver: RTL and testbench
=====================================

Name: matrix_scan_driver

Overview:
Consumes the 256-bit 16x16 frame produced by the physics block and drives a row-scanned LED matrix panel. Each row is sent as 16 serial column bits, latched, and then lit for a fixed on-time. A ready/valid input handshake with a double buffer lets the producer update frames at any time; the displayed frame changes only at frame boundaries, so tearing cannot occur.

Parameters:
CLK_DIV, 1, clk cycles per sclk half-period (>=1)
ON_CYCLES, 64, clk cycles oe_n is held low per row (>=1)

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset
matrix_in  input  256  frame, bit index row*16+col, 1 = LED on
frame_valid  input  1  producer offers matrix_in
frame_ready  output  1  high when shadow buffer is free
sclk  output  1  panel shift clock; data sampled on rising edge
sdata  output  1  panel serial column data
latch  output  1  one-cycle pulse transferring shift chain to column drivers
oe_n  output  1  active-low panel output enable
row_addr  output  4  row currently selected
frame_done  output  1  one-cycle pulse after row 15 display ends

Behaviour:
- Reset asserted (reset=0): immediate, asynchronous. sclk=0, sdata=0, latch=0, oe_n=1, row_addr=0, frame_done=0. front buffer=0, shadow=0, pending=0, row=0, state=IDLE. frame_ready=1 once reset is released.
- frame_ready = !pending (combinational from a register).
- Accept: frame_valid && frame_ready on an edge loads shadow <= matrix_in and sets pending <= 1.
- frame_valid while frame_ready=0 is ignored; no queuing.
- States: IDLE -> SHIFT -> LATCH -> DISPLAY -> (SHIFT | IDLE).
- IDLE: lasts exactly 1 cycle. If pending=1, then front <= shadow and pending <= 0. Otherwise the old front frame is re-displayed. Next state is SHIFT with col=15.
- A frame_valid arriving in the swap cycle is not accepted, because frame_ready is low. It is accepted on the following cycle.
- SHIFT: oe_n=1 (panel blanked).
  - Bits go out col 15 first, down to col 0.
  - sdata = front[row*16+col] and is stable for the whole bit.
  - Each bit is sclk low for CLK_DIV cycles, then sclk high for CLK_DIV cycles.
  - After 16 bits (32*CLK_DIV cycles), sclk=0 and the state goes to LATCH.
- LATCH: exactly 1 cycle. latch=1, row_addr <= row, oe_n=1.
- DISPLAY:
  - oe_n=0 for ON_CYCLES cycles, then oe_n returns to 1.
  - If row==15: row <= 0, frame_done=1 for 1 cycle, next state IDLE.
  - Otherwise row <= row+1, next state SHIFT.
- Timing:
  - Row period = 32*CLK_DIV + 1 + ON_CYCLES.
  - Frame period = 16*row period + 1.
  - Latency from accept to first lit pixel of the new frame is at most one frame period + row-0 shift + 1.
- Widths:
  - col is a 4-bit down-counter.
  - Row is 4 bits and wraps 15 -> 0 only through IDLE.
  - The divider counter is sized $clog2(CLK_DIV)+1.
  - The on-time counter is sized $clog2(ON_CYCLES)+1.
- Reset mid-operation (any state): outputs return to reset values in the same instant, pending is cleared, and the accepted-but-unswapped frame is discarded.
- latch and oe_n=0 are never asserted in the same cycle. sclk never toggles while oe_n=0.

Decomposition:
- Package display_pkg holds:
  - ROWS=16, COLS=16, ROW_W=4
  - the scan_state_t enum {IDLE, SHIFT, LATCH, DISPLAY}
  - the bit-index helper constant COLS for row*COLS+col
- Sub-module row_shifter:
  - inputs: 16-bit row word, start pulse
  - outputs: sclk, sdata, done
  - implements the CLK_DIV divider and the col down-counter
- The top level holds the buffers, handshake, row counter and FSM.

Test Plan:
1. Reset check. Hold reset=0 for 3 cycles, then release -> oe_n=1, sclk=0, latch=0, row_addr=0, frame_done=0, frame_ready=1.
2. Single-pixel frame. CLK_DIV=1, ON_CYCLES=4; push matrix_in with only bit 0 set -> row 0 shows 16 sclk rising edges, with sdata=1 only on the 16th edge. This is followed by one latch cycle with row_addr=0, then oe_n=0 for 4 cycles. All other rows shift all zeros.
3. Frame period. CLK_DIV=1, ON_CYCLES=4; free-run -> frame_done pulses every 593 cycles. row_addr sequences 0..15 and then wraps to 0.
4. Double buffer. Push frame A (all ones) and immediately B (checkerboard 0xAAAA/0x5555 rows); offer C -> frame_ready stays 0 with C held until the next IDLE swap. The frame after A displays B, and C is accepted one cycle after the swap.
5. Mid-shift reset. Drive reset=0 during the 7th bit of row 5 -> all outputs go to reset values without waiting for a clk edge. After release, the panel scans an all-zero frame from row 0.
6. Divider. CLK_DIV=3 -> each sclk phase lasts 3 cycles and sdata is stable across both phases. The row period is 96+1+ON_CYCLES.

Source files
------------

// File: rtl/display_pkg.sv
// Shared geometry and scan-state encoding for the LED matrix scan driver.
package display_pkg;

  localparam int ROWS  = 16;
  localparam int COLS  = 16;
  localparam int ROW_W = 4;
  localparam int COL_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH,
    DISPLAY
  } scan_state_t;

endpackage

// File: rtl/row_shifter.sv
// Serialises one 16-bit row word onto sclk/sdata, column 15 first, each bit
// shown as CLK_DIV low cycles followed by CLK_DIV high cycles.
module row_shifter
  import display_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [COLS-1:0] row_word_i,
  input  logic            start_i,
  output logic            sclk_o,
  output logic            sdata_o,
  output logic            done_o
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

  logic             busy_q, busy_d;
  logic             sclk_q, sclk_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             phase_end;

  assign phase_end = (div_q == '0);

  always_comb begin
    busy_d = busy_q;
    sclk_d = sclk_q;
    col_d  = col_q;
    div_d  = div_q;
    if (start_i) begin
      busy_d = 1'b1;
      sclk_d = 1'b0;
      col_d  = COL_W'(COLS - 1);
      div_d  = DIV_LOAD;
    end else if (busy_q) begin
      if (phase_end) begin
        div_d = DIV_LOAD;
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          // falling edge closes the bit; column 0 closes the whole row
          sclk_d = 1'b0;
          if (col_q == '0) busy_d = 1'b0;
          else             col_d  = col_q - 1'b1;
        end
      end else begin
        div_d = div_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      col_q  <= '0;
      div_q  <= '0;
    end else begin
      busy_q <= busy_d;
      sclk_q <= sclk_d;
      col_q  <= col_d;
      div_q  <= div_d;
    end
  end

  assign sclk_o  = sclk_q;
  assign sdata_o = busy_q ? row_word_i[col_q] : 1'b0;
  assign done_o  = busy_q && phase_end && sclk_q && (col_q == '0);

endmodule

// File: rtl/matrix_scan_driver.sv
// Row-scanned LED panel driver: double-buffered frame input, per-row shift,
// latch and fixed on-time; frames swap only in the IDLE slot between frames.
//
//   state   | meaning
//   IDLE    | one cycle between frames; promotes a pending shadow frame
//   SHIFT   | panel blanked, 16 column bits clocked out
//   LATCH   | one-cycle latch pulse, row_addr updated
//   DISPLAY | oe_n low for ON_CYCLES, then next row or back to IDLE
module matrix_scan_driver
  import display_pkg::*;
#(
  parameter int CLK_DIV   = 1,
  parameter int ON_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [255:0]     matrix_in,
  input  logic             frame_valid,
  output logic             frame_ready,
  output logic             sclk,
  output logic             sdata,
  output logic             latch,
  output logic             oe_n,
  output logic [ROW_W-1:0] row_addr,
  output logic             frame_done
);

  localparam int ON_W = $clog2(ON_CYCLES) + 1;

  scan_state_t      state_q, state_d;
  logic [255:0]     front_q, front_d;
  logic [255:0]     shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ROW_W-1:0] row_addr_q, row_addr_d;
  logic [ON_W-1:0]  on_cnt_q, on_cnt_d;
  logic             frame_done_q, frame_done_d;
  logic             shift_start;
  logic             shift_done;
  logic [7:0]       row_base;

  assign row_base = {row_q, 4'b0000};

  row_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_row_shifter (
    .clk        (clk),
    .rst_n      (reset),
    .row_word_i (front_q[row_base +: COLS]),
    .start_i    (shift_start),
    .sclk_o     (sclk),
    .sdata_o    (sdata),
    .done_o     (shift_done)
  );

  always_comb begin
    state_d      = state_q;
    front_d      = front_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    row_d        = row_q;
    row_addr_d   = row_addr_q;
    on_cnt_d     = on_cnt_q;
    frame_done_d = 1'b0;
    shift_start  = 1'b0;

    // accept and swap are exclusive: accept needs pending low, swap needs it high
    if (frame_valid && !pending_q) begin
      shadow_d  = matrix_in;
      pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pending_q) begin
          front_d   = shadow_q;
          pending_d = 1'b0;
        end
        state_d     = SHIFT;
        shift_start = 1'b1;
      end
      SHIFT: begin
        if (shift_done) state_d = LATCH;
      end
      LATCH: begin
        row_addr_d = row_q;
        on_cnt_d   = ON_W'(ON_CYCLES - 1);
        state_d    = DISPLAY;
      end
      DISPLAY: begin
        if (on_cnt_q == '0) begin
          if (row_q == ROW_W'(ROWS - 1)) begin
            row_d        = '0;
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            row_d       = row_q + 1'b1;
            state_d     = SHIFT;
            shift_start = 1'b1;
          end
        end else begin
          on_cnt_d = on_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      front_q      <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      row_q        <= '0;
      row_addr_q   <= '0;
      on_cnt_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      front_q      <= front_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      row_q        <= row_d;
      row_addr_q   <= row_addr_d;
      on_cnt_q     <= on_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_ready = !pending_q;
  assign latch       = (state_q == LATCH);
  assign oe_n        = (state_q != DISPLAY);
  assign row_addr    = row_addr_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Bench for matrix_scan_driver: two instances (CLK_DIV=1/ON=4 and CLK_DIV=3/ON=5)
// compared every cycle against a timeline model derived from row/frame arithmetic.
module tb_matrix_scan_driver;

  localparam int D0 = 1, ON0 = 4, D1 = 3, ON1 = 5;
  localparam int FP0 = 16 * (32 * D0 + 1 + ON0) + 1;
  localparam int FP1 = 16 * (32 * D1 + 1 + ON1) + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         frame_valid;
  logic [255:0] matrix_in;
  logic [1:0]   ready_w, sclk_w, sdata_w, latch_w, oen_w, done_w;
  logic [3:0]   row0_w, row1_w;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [255:0] m_front [2];
  logic [255:0] m_shadow[2];
  logic         m_pend  [2];
  int           m_c     [2];
  int           last_fd [2];

  always #5 clk = ~clk;

  matrix_scan_driver #(.CLK_DIV(D0), .ON_CYCLES(ON0)) u_dut0 (
    .clk(clk), .reset(reset), .matrix_in(matrix_in), .frame_valid(frame_valid),
    .frame_ready(ready_w[0]), .sclk(sclk_w[0]), .sdata(sdata_w[0]), .latch(latch_w[0]),
    .oe_n(oen_w[0]), .row_addr(row0_w), .frame_done(done_w[0])
  );

  matrix_scan_driver #(.CLK_DIV(D1), .ON_CYCLES(ON1)) u_dut1 (
    .clk(clk), .reset(reset), .matrix_in(matrix_in), .frame_valid(frame_valid),
    .frame_ready(ready_w[1]), .sclk(sclk_w[1]), .sdata(sdata_w[1]), .latch(latch_w[1]),
    .oe_n(oen_w[1]), .row_addr(row1_w), .frame_done(done_w[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected pin values for cycle c after reset release, from the frame timeline.
  task automatic model_out(input int d, input int on, input int c, input logic [255:0] fr,
                           output logic e_sclk, output logic e_sdata, output logic e_latch,
                           output logic e_oen, output logic e_done, output logic [3:0] e_row);
    int rp, fp, k, o, r, p;
    rp = 32 * d + 1 + on;
    fp = 16 * rp + 1;
    k = c / fp;
    o = c % fp;
    e_sclk = 1'b0; e_sdata = 1'b0; e_latch = 1'b0; e_oen = 1'b1;
    e_done = (o == 0) && (k > 0);
    e_row  = (k > 0) ? 4'd15 : 4'd0;
    if (o > 0) begin
      r = (o - 1) / rp;
      p = (o - 1) % rp;
      if (p > 32 * d) e_row = 4'(r);
      else if (r > 0) e_row = 4'(r - 1);
      if (p < 32 * d) begin
        e_sclk  = (p % (2 * d)) >= d;
        e_sdata = fr[r * 16 + 15 - p / (2 * d)];
      end else if (p == 32 * d) begin
        e_latch = 1'b1;
      end else begin
        e_oen = 1'b0;
      end
    end
  endtask

  task automatic model_edge(input logic v, input logic [255:0] m);
    for (int i = 0; i < 2; i++) begin
      int fp;
      fp = (i == 0) ? FP0 : FP1;
      if ((m_c[i] % fp) == 0 && m_pend[i]) begin
        m_front[i] = m_shadow[i];
        m_pend[i]  = 1'b0;
      end else if (v && !m_pend[i]) begin
        m_shadow[i] = m;
        m_pend[i]   = 1'b1;
      end
      m_c[i]++;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      logic es, ed, el, eo, ef;
      logic [3:0] er;
      int d, on, fp;
      d  = (i == 0) ? D0 : D1;
      on = (i == 0) ? ON0 : ON1;
      fp = (i == 0) ? FP0 : FP1;
      model_out(d, on, m_c[i], m_front[i], es, ed, el, eo, ef, er);
      chk($sformatf("sclk%0d@%0d", i, cyc), sclk_w[i], es);
      chk($sformatf("sdata%0d@%0d", i, cyc), sdata_w[i], ed);
      chk($sformatf("latch%0d@%0d", i, cyc), latch_w[i], el);
      chk($sformatf("oe_n%0d@%0d", i, cyc), oen_w[i], eo);
      chk($sformatf("frame_done%0d@%0d", i, cyc), done_w[i], ef);
      chk($sformatf("row_addr%0d@%0d", i, cyc), (i == 0) ? row0_w : row1_w, er);
      chk($sformatf("frame_ready%0d@%0d", i, cyc), ready_w[i], !m_pend[i]);
      if (done_w[i]) begin
        if (last_fd[i] >= 0) chk($sformatf("fd_gap%0d@%0d", i, cyc), cyc - last_fd[i], fp);
        last_fd[i] = cyc;
      end
    end
  endtask

  task automatic check_rst();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_sclk%0d", i), sclk_w[i], 1'b0);
      chk($sformatf("rst_sdata%0d", i), sdata_w[i], 1'b0);
      chk($sformatf("rst_latch%0d", i), latch_w[i], 1'b0);
      chk($sformatf("rst_oe_n%0d", i), oen_w[i], 1'b1);
      chk($sformatf("rst_frame_done%0d", i), done_w[i], 1'b0);
      chk($sformatf("rst_row_addr%0d", i), (i == 0) ? row0_w : row1_w, 4'd0);
    end
  endtask

  task automatic do_reset(input int n);
    reset       = 1'b0;
    frame_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_front[i] = '0; m_shadow[i] = '0; m_pend[i] = 1'b0; m_c[i] = 0; last_fd[i] = -1;
    end
    #1;
    check_rst();
    repeat (n) begin
      @(negedge clk);
      check_rst();
    end
    reset = 1'b1;
  endtask

  // One clock: check current cycle, drive inputs, advance model, move to next negedge.
  task automatic cycle(input logic v, input logic [255:0] m, output logic acc0);
    check_all();
    frame_valid = v;
    matrix_in   = m;
    acc0 = v && !m_pend[0];
    model_edge(v, m);
    cyc++;
    @(negedge clk);
  endtask

  function automatic logic [255:0] rand_frame();
    logic [255:0] f;
    for (int k = 0; k < 8; k++) f[k * 32 +: 32] = $urandom;
    return f;
  endfunction

  initial begin
    logic         acc;
    logic [255:0] q[$];
    logic [255:0] single;
    int           budget;

    reset = 1'b1; frame_valid = 1'b0; matrix_in = '0;
    #2;
    do_reset(3);

    single = '0;
    single[0] = 1'b1;
    cycle(1'b1, single, acc);
    repeat (2 * FP0 + 50) cycle(1'b0, '0, acc);

    q.push_back({256{1'b1}});
    q.push_back({8{16'h5555, 16'hAAAA}});
    q.push_back(rand_frame());
    budget = 0;
    while (q.size() > 0 && budget < 4 * FP0) begin
      cycle(1'b1, q[0], acc);
      if (acc) void'(q.pop_front());
      budget++;
    end
    if (q.size() > 0) chk("dbuf_timeout", q.size(), 0);
    repeat (2 * FP0) cycle(1'b0, '0, acc);

    repeat (3000) cycle(($urandom_range(0, 15) == 0), rand_frame(), acc);

    budget = 0;
    while ((m_c[0] % FP0) != (1 + 5 * (32 * D0 + 1 + ON0) + 6 * 2 * D0) && budget < 2 * FP0) begin
      cycle(1'b0, '0, acc);
      budget++;
    end
    if (budget >= 2 * FP0) chk("midreset_timeout", budget, 0);
    #2;
    do_reset(2);
    repeat (2 * FP0 + 20) cycle(1'b0, '0, acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
